time_entry: RTL and testbench

User time-entry front end for the microwave controller: reads the digit switches and the digit/start/clear pushbuttons, shifts digits in right to left (keypad style, MM:SS), validates the entry and hands a BCD time to the countdown block with a one-cycle load strobe. It drives the input side of the same HEX/timer path whose output side shows the countdown and the blinking "End". Its outputs feed the countdown loader and the HEX digit encoders during entry.

---
 rtl/time_entry_pkg.sv | 21 ++
 rtl/time_entry_key_edge.sv | 26 ++
 rtl/time_entry.sv | 164 ++++++++++++++++
 tb/tb_time_entry.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_entry_pkg.sv
// Shared types and constants for the microwave time-entry front end.
package time_entry_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int MAX_MIN    = 99;
    localparam int MAX_SEC    = 59;

    // BCD forms of the limits; seconds >= 60 is equivalent to tens digit >= 6.
    localparam logic [7:0] MAX_MIN_BCD    = 8'(((MAX_MIN / 10) << 4) | (MAX_MIN % 10));
    localparam logic [7:0] MAX_SEC_BCD    = 8'(((MAX_SEC / 10) << 4) | (MAX_SEC % 10));
    localparam logic [3:0] SEC_TENS_LIMIT = 4'((MAX_SEC + 1) / 10);

endpackage

// File: rtl/time_entry_key_edge.sv
// Pushbutton synchronizer and falling-edge detector: one registered pulse per press.
module key_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync  <= '1;
            prev  <= 1'b1;
            press <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], key};
            prev  <= sync[SYNC_STAGES-1];
            press <= prev & ~sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/time_entry.sv
// Keypad-style MM:SS entry, validation and countdown load/cancel control.
// Optional seconds normalization (0:90 -> 1:30) enabled by TIME_ENTRY_NORMALIZE_EN.
module time_entry
    import time_entry_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   digitIn,
    input  logic         digitKey,
    input  logic         startKey,
    input  logic         clearKey,
    input  logic         doneIn,
    output logic [15:0]  timeOut,
    output logic         loadOut,
    output logic         cancelOut,
    output logic         errOut,
    output logic         running
);

    state_t      state, state_nxt;
    logic [2:0]  count, count_nxt;
    logic [15:0] time_nxt;
    logic        load_nxt, cancel_nxt, err_nxt, running_nxt;
    logic        digit_ev, start_ev, clear_ev;
    logic        clr_e, st_e, dg_e;
    logic        digit_ok, start_ok, is_zero;

`ifdef TIME_ENTRY_NORMALIZE_EN
    // Fold seconds >= 60 into the minutes, saturating at the largest displayable time.
    function automatic logic [15:0] normalize_time(input logic [15:0] t);
        logic [3:0] mt, mo;
        if (t[7:4] < SEC_TENS_LIMIT)
            return t;
        if (t[15:8] == MAX_MIN_BCD)
            return {MAX_MIN_BCD, MAX_SEC_BCD};
        if (t[11:8] == 4'd9) begin
            mt = t[15:12] + 4'd1;
            mo = 4'd0;
        end else begin
            mt = t[15:12];
            mo = t[11:8] + 4'd1;
        end
        return {mt, mo, t[7:4] - SEC_TENS_LIMIT, t[3:0]};
    endfunction
`endif

    key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_digit (
        .clock(clock), .reset(reset), .key(digitKey), .press(digit_ev));
    key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
        .clock(clock), .reset(reset), .key(startKey), .press(start_ev));
    key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clear (
        .clock(clock), .reset(reset), .key(clearKey), .press(clear_ev));

    // Same-cycle priority: clear > start > digit.
    assign clr_e = clear_ev;
    assign st_e  = start_ev & ~clear_ev;
    assign dg_e  = digit_ev & ~clear_ev & ~start_ev;

    assign is_zero  = (timeOut == 16'h0000);
    assign digit_ok = dg_e && (digitIn <= 4'd9) && (count < 3'(NUM_DIGITS))
                      && ((state == IDLE) || (state == ENTRY));
`ifdef TIME_ENTRY_NORMALIZE_EN
    assign start_ok = !is_zero;
`else
    assign start_ok = !is_zero && (timeOut[7:4] < SEC_TENS_LIMIT);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 3'd0;
            timeOut   <= 16'h0000;
            loadOut   <= 1'b0;
            cancelOut <= 1'b0;
            errOut    <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            timeOut   <= time_nxt;
            loadOut   <= load_nxt;
            cancelOut <= cancel_nxt;
            errOut    <= err_nxt;
            running   <= running_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (digit_ok) state_nxt = ENTRY;
            ENTRY:   if (clr_e) state_nxt = IDLE;
                     else if (st_e && start_ok) state_nxt = LOAD;
            LOAD:    state_nxt = clr_e ? IDLE : RUN;
            RUN:     if (doneIn || clr_e) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        time_nxt    = timeOut;
        count_nxt   = count;
        load_nxt    = 1'b0;
        cancel_nxt  = 1'b0;
        err_nxt     = 1'b0;
        running_nxt = running;
        case (state)
            IDLE: begin
                if (digit_ok) begin
                    time_nxt  = {timeOut[11:0], digitIn};
                    count_nxt = count + 3'd1;
                end
            end
            ENTRY: begin
                if (clr_e) begin
                    time_nxt  = 16'h0000;
                    count_nxt = 3'd0;
                end else if (st_e) begin
                    if (start_ok) begin
`ifdef TIME_ENTRY_NORMALIZE_EN
                        time_nxt = normalize_time(timeOut);
`endif
                        load_nxt    = 1'b1;
                        running_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else if (digit_ok) begin
                    time_nxt  = {timeOut[11:0], digitIn};
                    count_nxt = count + 3'd1;
                end
            end
            LOAD: begin
                // loadOut is already high this cycle; a clear here aborts right after.
                if (clr_e) begin
                    time_nxt    = 16'h0000;
                    count_nxt   = 3'd0;
                    cancel_nxt  = 1'b1;
                    running_nxt = 1'b0;
                end
            end
            RUN: begin
                if (doneIn) begin
                    time_nxt    = 16'h0000;
                    count_nxt   = 3'd0;
                    running_nxt = 1'b0;
                end else if (clr_e) begin
                    time_nxt    = 16'h0000;
                    count_nxt   = 3'd0;
                    cancel_nxt  = 1'b1;
                    running_nxt = 1'b0;
                end
            end
            default: begin
                time_nxt    = 16'h0000;
                count_nxt   = 3'd0;
                running_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: scenario tasks plus a load-value scoreboard.
module tb_time_entry;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  digitIn = 4'd0;
    logic        digitKey = 1'b1;
    logic        startKey = 1'b1;
    logic        clearKey = 1'b1;
    logic        doneIn = 1'b0;
    logic [15:0] timeOut;
    logic        loadOut, cancelOut, errOut, running;

    int n_checks = 0;
    int n_fail   = 0;
    int load_cnt = 0;
    int err_cnt  = 0;
    int cancel_cnt = 0;
    logic [15:0] exp_load_q[$];

    time_entry #(.SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .digitIn(digitIn),
        .digitKey(digitKey), .startKey(startKey), .clearKey(clearKey),
        .doneIn(doneIn), .timeOut(timeOut), .loadOut(loadOut),
        .cancelOut(cancelOut), .errOut(errOut), .running(running));

    always #5 clock = ~clock;

    // Scoreboard: every loadOut pulse must match the next expected load value.
    always @(negedge clock) begin
        if (!reset) begin
            if (loadOut) begin
                load_cnt++;
                n_checks++;
                if (exp_load_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL load_unexpected: timeOut=%h with no load expected", timeOut);
                end else begin
                    logic [15:0] e;
                    e = exp_load_q.pop_front();
                    if (timeOut !== e || running !== 1'b1) begin
                        n_fail++;
                        $display("FAIL load_value: timeOut=%h running=%b, expected %h running=1",
                                 timeOut, running, e);
                    end
                end
            end
            if (errOut) err_cnt++;
            if (cancelOut) cancel_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // kind: 0 digit, 1 start, 2 clear, 3 clear+digit together
    task automatic press(input int kind, input logic [3:0] d);
        tick(1);
        digitIn = d;
        if (kind == 0 || kind == 3) digitKey = 1'b0;
        if (kind == 1) startKey = 1'b0;
        if (kind == 2 || kind == 3) clearKey = 1'b0;
        tick(6);
        digitKey = 1'b1;
        startKey = 1'b1;
        clearKey = 1'b1;
        tick(6);
    endtask

    task automatic enter(input logic [15:0] digs, input int n);
        for (int i = n - 1; i >= 0; i--) press(0, digs[i*4 +: 4]);
    endtask

    task automatic check_time(input string name, input logic [15:0] e);
        @(negedge clock);
        n_checks++;
        if (timeOut !== e) begin
            n_fail++;
            $display("FAIL %s: timeOut=%h expected %h", name, timeOut, e);
        end
    endtask

    task automatic pulse_done();
        tick(1);
        doneIn = 1'b1;
        tick(1);
        doneIn = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(4);
        @(negedge clock);
        n_checks++;
        if (timeOut !== 16'h0 || loadOut !== 1'b0 || cancelOut !== 1'b0 ||
            errOut !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: time=%h load=%b cancel=%b err=%b run=%b expected all 0",
                     timeOut, loadOut, cancelOut, errOut, running);
        end
        reset = 1'b0;
        tick(4);
        check_time("idle_after_reset", 16'h0000);
    endtask

    task automatic test_basic();
        int l0;
        l0 = load_cnt;
        enter(16'h0130, 3);
        check_time("basic_entry", 16'h0130);
        exp_load_q.push_back(16'h0130);
        press(1, 4'd0);
        @(negedge clock);
        n_checks++;
        if (load_cnt - l0 != 1 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_load: loads=%0d running=%b expected 1 load running=1",
                     load_cnt - l0, running);
        end
        check_time("basic_run_hold", 16'h0130);
        pulse_done();
        @(negedge clock);
        n_checks++;
        if (timeOut !== 16'h0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: timeOut=%h running=%b expected 0000 0", timeOut, running);
        end
    endtask

    task automatic test_digit_limits();
        enter(16'h2345, 4);
        press(0, 4'd1);
        press(0, 4'd5);
        check_time("digit_cap", 16'h2345);
        press(2, 4'd0);
        enter(16'h1234, 4);
        press(0, 4'd5);
        check_time("five_digits", 16'h1234);
        press(2, 4'd0);
        press(0, 4'd7);
        press(0, 4'hC);
        check_time("invalid_digit", 16'h0007);
        press(2, 4'd0);
        check_time("clear_entry", 16'h0000);
    endtask

    task automatic test_seconds_rule();
        int l0, e0;
        enter(16'h0059, 2);
        exp_load_q.push_back(16'h0059);
        press(1, 4'd0);
        pulse_done();
        l0 = load_cnt;
        e0 = err_cnt;
        enter(16'h0090, 2);
`ifdef TIME_ENTRY_NORMALIZE_EN
        exp_load_q.push_back(16'h0130);
        press(1, 4'd0);
        @(negedge clock);
        n_checks++;
        if (load_cnt - l0 != 1 || err_cnt != e0) begin
            n_fail++;
            $display("FAIL norm_090: loads=%0d errs=%0d expected 1 0", load_cnt - l0, err_cnt - e0);
        end
        pulse_done();
        enter(16'h9999, 4);
        exp_load_q.push_back(16'h9959);
        press(1, 4'd0);
        check_time("norm_sat", 16'h9959);
        pulse_done();
`else
        press(1, 4'd0);
        @(negedge clock);
        n_checks++;
        if (load_cnt != l0 || err_cnt - e0 != 1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_090: loads=%0d errs=%0d running=%b expected 0 1 0",
                     load_cnt - l0, err_cnt - e0, running);
        end
        check_time("reject_keeps_digits", 16'h0090);
        press(0, 4'd1);
        check_time("still_entry", 16'h0901);
        press(2, 4'd0);
`endif
    endtask

    task automatic test_zero_start();
        int l0, e0;
        l0 = load_cnt;
        e0 = err_cnt;
        press(0, 4'd0);
        press(1, 4'd0);
        @(negedge clock);
        n_checks++;
        if (load_cnt != l0 || err_cnt - e0 != 1) begin
            n_fail++;
            $display("FAIL zero_start: loads=%0d errs=%0d expected 0 1", load_cnt - l0, err_cnt - e0);
        end
        press(2, 4'd0);
        e0 = err_cnt;
        press(1, 4'd0);
        @(negedge clock);
        n_checks++;
        if (load_cnt != l0 || err_cnt != e0 || timeOut !== 16'h0) begin
            n_fail++;
            $display("FAIL idle_start: loads=%0d errs=%0d time=%h expected 0 0 0000",
                     load_cnt - l0, err_cnt - e0, timeOut);
        end
    endtask

    task automatic test_cancel();
        int c0;
        c0 = cancel_cnt;
        press(0, 4'd2);
        exp_load_q.push_back(16'h0002);
        press(1, 4'd0);
        press(2, 4'd0);
        @(negedge clock);
        n_checks++;
        if (cancel_cnt - c0 != 1 || timeOut !== 16'h0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL run_cancel: cancels=%0d time=%h running=%b expected 1 0000 0",
                     cancel_cnt - c0, timeOut, running);
        end
        c0 = cancel_cnt;
        press(0, 4'd3);
        exp_load_q.push_back(16'h0003);
        press(1, 4'd0);
        tick(1);
        clearKey = 1'b0;
        tick(3);
        doneIn = 1'b1;
        tick(1);
        doneIn = 1'b0;
        tick(4);
        clearKey = 1'b1;
        tick(6);
        @(negedge clock);
        n_checks++;
        if (cancel_cnt != c0 || timeOut !== 16'h0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL done_beats_clear: cancels=%0d time=%h running=%b expected 0 0000 0",
                     cancel_cnt - c0, timeOut, running);
        end
    endtask

    task automatic test_hold_and_priority();
        tick(1);
        digitIn = 4'd7;
        digitKey = 1'b0;
        tick(1000);
        digitKey = 1'b1;
        tick(6);
        check_time("hold_one_digit", 16'h0007);
        press(3, 4'd8);
        check_time("clear_beats_digit", 16'h0000);
        press(0, 4'd1);
        check_time("count_reset", 16'h0001);
        press(2, 4'd0);
    endtask

    task automatic test_reset_run();
        int c0;
        c0 = cancel_cnt;
        press(0, 4'd4);
        exp_load_q.push_back(16'h0004);
        press(1, 4'd0);
        tick(1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        @(negedge clock);
        n_checks++;
        if (cancel_cnt != c0 || timeOut !== 16'h0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_run: cancels=%0d time=%h running=%b expected 0 0000 0",
                     cancel_cnt - c0, timeOut, running);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_digit_limits();
        test_seconds_rule();
        test_zero_start();
        test_cancel();
        test_hold_and_priority();
        test_reset_run();
        tick(4);
        n_checks++;
        if (exp_load_q.size() != 0) begin
            n_fail++;
            $display("FAIL load_missing: %0d expected loads never seen", exp_load_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
